// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sevseg_pkg
//  Purpose  : Shared types, active-low segment patterns and special codes
//             for the seven-segment scan driver.
//  Revision : 1.0  initial release
// ============================================================================
package sevseg_pkg;

  typedef logic [6:0] seg_t;

  // Segment order {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_DASH  = 7'b1111110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_E    = 4'hA;
  localparam logic [3:0] CODE_F    = 4'hC;
  localparam logic [3:0] CODE_DASH = 4'hD;

endpackage
`default_nettype wire

// File: rtl/sevseg_code_lut.sv
`default_nettype none
// ============================================================================
//  Module   : sevseg_code_lut
//  Purpose  : Combinational 4-bit display code to active-low segment pattern.
//  Revision : 1.0  initial release
// ============================================================================
module sevseg_code_lut
  import sevseg_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (code)
      4'h0:      seg_n = SEG_0;
      4'h1:      seg_n = SEG_1;
      4'h2:      seg_n = SEG_2;
      4'h3:      seg_n = SEG_3;
      4'h4:      seg_n = SEG_4;
      4'h5:      seg_n = SEG_5;
      4'h6:      seg_n = SEG_6;
      4'h7:      seg_n = SEG_7;
      4'h8:      seg_n = SEG_8;
      4'h9:      seg_n = SEG_9;
      CODE_E:    seg_n = SEG_E;
      CODE_F:    seg_n = SEG_F;
      CODE_DASH: seg_n = SEG_DASH;
      default:   seg_n = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sevseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : sevseg_scan_driver
//  Purpose  : Multiplexed common-anode seven-segment driver with frame-
//             synchronous display update and leading-zero blanking.
//             Optional decimal points when SEVSEG_DP_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic                  blank_lz,
`ifdef SEVSEG_DP_EN
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  dp_n,
`endif
  output logic [6:0]            seg_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VAL_W = 4 * N_DIGITS;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic [VAL_W-1:0]    disp_q, disp_d;
  logic [VAL_W-1:0]    shadow_q, shadow_d;
  logic                pending_q, pending_d;
  seg_t                seg_n_q, seg_n_d;
  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic                frame_done_q, frame_done_d;

  logic       cnt_wrap;
  logic       dig_last;
  logic       frame_end;
  logic [3:0] nibble;
  logic       lz_run;
  logic       sel_blank;
  seg_t       lut_seg;

  assign cnt_wrap  = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign dig_last  = (dig_q == DIG_W'(N_DIGITS - 1));
  assign frame_end = cnt_wrap && dig_last;

  always_comb begin
    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    dig_d = dig_q;
    if (cnt_wrap) begin
      dig_d = dig_last ? '0 : dig_q + 1'b1;
    end
  end

  // A load on the frame boundary itself bypasses the shadow register.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (load) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        disp_d = value_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end
  end

  // Walk from the MSD down so lz_run means "all higher digits are zero".
  always_comb begin
    nibble    = 4'h0;
    lz_run    = 1'b1;
    sel_blank = 1'b0;
    an_n_d    = '1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run && (disp_q[4*k +: 4] == 4'h0);
      if (dig_q == DIG_W'(k)) begin
        nibble    = disp_q[4*k +: 4];
        an_n_d[k] = 1'b0;
        sel_blank = blank_lz && lz_run && (k != 0);
      end
    end
  end

  sevseg_code_lut u_lut (
    .code  (nibble),
    .seg_n (lut_seg)
  );

  always_comb begin
    seg_n_d      = sel_blank ? SEG_BLANK : lut_seg;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

`ifdef SEVSEG_DP_EN
  logic [N_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
  logic [N_DIGITS-1:0] dp_disp_q, dp_disp_d;
  logic                dp_n_q, dp_n_d;

  // Decimal points follow the same commit rule and ignore blanking.
  always_comb begin
    dp_shadow_d = load ? dp_in : dp_shadow_q;
    dp_disp_d   = dp_disp_q;
    if (frame_end) begin
      if (load) begin
        dp_disp_d = dp_in;
      end else if (pending_q) begin
        dp_disp_d = dp_shadow_q;
      end
    end
    dp_n_d = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (dig_q == DIG_W'(k)) begin
        dp_n_d = ~dp_disp_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_shadow_q <= '0;
      dp_disp_q   <= '0;
      dp_n_q      <= 1'b1;
    end else begin
      dp_shadow_q <= dp_shadow_d;
      dp_disp_q   <= dp_disp_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign dp_n = dp_n_q;
`endif

endmodule
`default_nettype wire

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview: Time-multiplexed driver for a bank of N_DIGITS common-anode seven-segment digits sharing one segment bus. It holds a frame-synchronous display register loaded through a strobe, scans one digit per SCAN_DIV clocks, and decodes the 4-bit code of the active digit. It supports optional leading-zero blanking and drives active-low segment and anode outputs. It sits between counter/ALU logic and the board display pins, and is the multi-digit, registered successor to the single-digit combinational decoder.

Parameters:
N_DIGITS, 4, number of digits scanned; legal range 1..8.
SCAN_DIV, 50000, clocks each digit stays enabled; must be >= 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
load  in  1  single-cycle strobe that captures value_in.
value_in  in  4*N_DIGITS  digit codes; nibble k belongs to digit k, and digit 0 is the LSD.
blank_lz  in  1  enables leading-zero blanking; sampled every cycle.
seg_n  out  7  segments {a,b,c,d,e,f,g}, a=MSB, active-low.
an_n  out  N_DIGITS  digit enables, active-low, one-hot-low while scanning.
frame_done  out  1  one-cycle pulse when the digit N_DIGITS-1 slot ends.

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous and active-high. It clears: prescaler cnt=0, digit index dig=0, disp=0, shadow=0, pending=0, seg_n=7'h7F, an_n=all 1, frame_done=0.
- Prescaler: cnt counts 0..SCAN_DIV-1. At cnt==SCAN_DIV-1, cnt wraps to 0 and dig advances. dig wraps from N_DIGITS-1 to 0.
- Output timing: seg_n, an_n and frame_done are registered and reflect the state of dig/cnt one clock later. After reset is released, the first clock drives an_n bit 0 low. Each digit is low for exactly SCAN_DIV cycles.
- frame_done is 1 for the single cycle following cnt==SCAN_DIV-1 with dig==N_DIGITS-1.
- Loading: load=1 writes value_in into shadow and sets pending.
  - Several loads before a commit: last one wins.
- Commit: at cnt==SCAN_DIV-1 with dig==N_DIGITS-1 (the frame boundary), if pending, then disp<=shadow and pending<=0. No tearing occurs mid-frame.
  - load on the boundary cycle itself: value_in goes straight to disp and pending is left 0.
- Decode (active-low) of the disp nibble for dig:
  - Codes 0..9: standard digits. 0=7'b0000001, 1=7'b1001111, 2=7'b0010010, 3=7'b0000110, 4=7'b1001100, 5=7'b0100100, 6=7'b0100000, 7=7'b0001111, 8=7'b0000000, 9=7'b0000100.
  - Code A: 'E' = 7'b0110000.
  - Code C: 'F' = 7'b0111000.
  - Code D: '-' = 7'b1111110.
  - Codes B, E, F: blank = 7'b1111111.
  - The decode is fully specified; no latches.
- Leading-zero blanking: when blank_lz=1, digit k is blanked (seg_n=7'h7F, an_n still driven) if every nibble of disp from N_DIGITS-1 down to k is 0. Digit 0 is never blanked, so value 0 shows "0".
- N_DIGITS=1: dig stays 0, frame_done pulses every SCAN_DIV cycles, and commit happens at every wrap.
- Reset mid-frame: everything returns to reset values on the next edge. Any pending load is discarded.

Optional Feature:
SEVSEG_DP_EN
- Defined: adds input dp_in[N_DIGITS-1:0] and output dp_n (1 bit, active-low).
  - dp_in is captured into shadow alongside value_in and committed with the same frame rule.
  - dp_n = ~dp_disp[dig], registered with the same latency as seg_n.
  - dp_n resets to 1.
  - Leading-zero blanking never suppresses a set decimal point.
- Undefined: dp_in/dp_n ports and their registers are absent; behaviour is otherwise identical.

Decomposition:
- Package sevseg_pkg:
  - segment pattern localparams (SEG_0..SEG_9, SEG_E, SEG_F, SEG_DASH, SEG_BLANK);
  - code constants (CODE_E=4'hA, CODE_F=4'hC, CODE_DASH=4'hD);
  - typedef seg_t = logic [6:0].
- Sub-module sevseg_code_lut: purely combinational 4-bit code -> seg_t, active-low. It is instantiated once on the muxed nibble.
- Prescaler, scan counter, shadow/commit logic and blanking logic stay in the top module.

Test Plan:
1. N_DIGITS=4, SCAN_DIV=4. Hold rst 3 cycles, then release.
   -> an_n sequence 1110,1101,1011,0111 repeating, 4 cycles each. frame_done pulses every 16 cycles. seg_n=7'b0000001 (all zeros shown).
2. load value_in=16'h1234 mid-frame (digit 1 active).
   -> current frame unchanged. After the next frame_done, digit3='1'(7'b1001111) and digit0='4'(7'b1001100).
3. Two loads 16'h5678 then 16'h9ABC within one frame; a third load 16'hDDDD exactly on the boundary cycle.
   -> the next frame shows DDDD ('-' = 7'b1111110 on all digits). 9ABC is never displayed.
4. blank_lz=1, value 16'h0040.
   -> digits 3 and 2 show 7'h7F, digit1='4', digit0='0'. With value 16'h0000, only digit0 shows '0'.
5. Codes B, E, F loaded (16'hBEF0).
   -> digits 3..1 show 7'h7F, digit0 shows '0'. No X on seg_n at any time.
6. With SEVSEG_DP_EN: load dp_in=4'b0100, then assert rst mid-frame.
   -> dp_n=0 only while digit 2 is active. After rst, dp_n=1, an_n=4'hF for one cycle, and the display returns to 0000.
